input_fetch_arbiter: RTL and testbench
======================================

Name: input_fetch_arbiter

Overview:
- Shares one input-vector SRAM read port among NUM_REQ MVM tile controllers.
- Each tile controller raises input_req while it waits for input. This block grants requesters round-robin, issues one memory read, and waits a fixed MEM_LATENCY.
- It then returns the data with a one-cycle input_ready pulse to the granted tile.
- It sits between the tile controllers (and their width/height index logic) and the input buffer memory.

Parameters:
- NUM_REQ, 4, number of requesting tile controllers (2..16).
- REQ_LOG, 2, clog2(NUM_REQ); width of grant_id and rr_ptr.
- ADDR_WIDTH, 8, input buffer address width.
- DATA_WIDTH, 8, input operand width.
- MEM_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data; must be >= 1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- input_req  input  NUM_REQ  level request per tile; held high until served.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed read address per tile; slice i belongs to requester i.
- mem_rd_en  output  1  read strobe to the input buffer.
- mem_rd_addr  output  ADDR_WIDTH  read address; valid while mem_rd_en is high.
- mem_rd_data  input  DATA_WIDTH  read data; valid MEM_LATENCY cycles after mem_rd_en.
- input_ready  output  NUM_REQ  one-hot one-cycle delivery pulse.
- input_data  output  DATA_WIDTH  registered data; valid from the input_ready cycle and held until the next capture.
- grant_id  output  REQ_LOG  index of the requester being served.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Registered FSM with states IDLE, ISSUE, WAIT_DATA, DELIVER; all outputs except input_data and grant_id decode combinationally from state.
- Reset (any state, including mid-service):
  - state=IDLE, rr_ptr=0, grant_id=0, input_data=0, latency counter=0.
  - mem_rd_en=0, input_ready=0, busy=0.
  - No pending delivery survives reset.
- IDLE:
  - If any input_req bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch grant_id and that requester's address; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_rd_en=1, mem_rd_addr=latched address.
  - Load counter with MEM_LATENCY-1; go to WAIT_DATA.
- WAIT_DATA (exactly MEM_LATENCY cycles):
  - Counter decrements each cycle.
  - When counter==0, capture mem_rd_data into input_data at that edge and go to DELIVER.
- DELIVER (exactly 1 cycle):
  - input_ready[grant_id]=1; all other bits 0.
  - rr_ptr <= (grant_id+1) mod NUM_REQ; go to IDLE.
- Latency and throughput:
  - Request first visible in IDLE at cycle T: mem_rd_en at T+1, input_ready at T+2+MEM_LATENCY.
  - Service period is MEM_LATENCY+3 cycles.
  - At most one outstanding read; no pipelining.
- Requests arriving while busy stay pending (level-held) and are arbitrated at the next IDLE cycle.
- A requester that drops input_req mid-service still receives its input_ready pulse; there is no abort path.
- The served requester drops input_req on the edge ending DELIVER, so it is not re-granted in the following IDLE cycle.
- mem_rd_addr is driven from the latched register; changes to req_addr after the grant are ignored.
- rr_ptr wrap: from NUM_REQ-1 it goes to 0.
- Non-power-of-two NUM_REQ: unused pointer codes never occur.

Decomposition:
- Shared header sys_defs.svh carries:
  - NUM_REQ, REQ_LOG, ADDR_WIDTH, DATA_WIDTH, MEM_LATENCY defaults;
  - the 2-bit state encodings (IDLE=0, ISSUE=1, WAIT_DATA=2, DELIVER=3).
- One natural sub-module: rr_priority_picker. It is purely combinational: inputs are the request vector and rr_ptr; outputs are a grant index and an any_req flag. It is reused by future arbiters.

Test Plan:
- Single request, MEM_LATENCY=2: after reset, input_req=0001 and req_addr[0]=0x12 at cycle T; memory model returns 0xA5.
  -> mem_rd_en and mem_rd_addr=0x12 at T+1; input_ready=0001 and input_data=0xA5 at T+4; busy low at T+5.
- All four requests held from T:
  -> grants in order 0,1,2,3; input_ready pulses at T+4, T+9, T+14, T+19; each deliver cycle is one-hot and matches grant_id.
- Fairness: requesters 0 and 2 held high continuously.
  -> grant sequence 0,2,0,2,0; requester 0 never served twice in a row.
- Reset asserted during WAIT_DATA while serving requester 1.
  -> no input_ready pulse; next cycle busy=0, input_data=0, rr_ptr=0; then with req=1010, requester 1 is granted first.
- Requester 3 drops input_req the cycle after ISSUE.
  -> exactly one input_ready=1000 pulse at the scheduled cycle; arbiter returns to IDLE and stays there.
- MEM_LATENCY=1 build, request at T.
  -> mem_rd_en at T+1; input_ready at T+3; service period 4 cycles.

Source files
------------

// File: rtl/input_fetch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// input_fetch_arbiter_pkg
// Shared definitions for the input fetch arbiter and its round-robin picker.
//   - default build parameters (requesters, widths, memory latency)
//   - 2-bit FSM state encoding (IDLE=0, ISSUE=1, WAIT_DATA=2, DELIVER=3)
//   - modulo helpers for round-robin pointer arithmetic
// -----------------------------------------------------------------------------
package input_fetch_arbiter_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int REQ_LOG_DEF     = 2;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int MEM_LATENCY_DEF = 2;

  typedef int unsigned uint_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DELIVER   = 2'd3
  } fetch_state_t;

  // (base + off) mod n, valid for base < n and off < n; avoids a divider.
  function automatic uint_t wrap_add(input uint_t base, input uint_t off, input uint_t n);
    uint_t sum_v;
    sum_v = base + off;
    return (sum_v >= n) ? (sum_v - n) : sum_v;
  endfunction

  // (v + 1) mod n for v < n.
  function automatic uint_t wrap_inc(input uint_t v, input uint_t n);
    return wrap_add(v, 32'd1, n);
  endfunction

endpackage

// File: rtl/input_fetch_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin selector: returns the first set request
// bit found searching upward from rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  REQ_LOG  highest-priority index (must be < NUM_REQ)
//   grant_idx out REQ_LOG  selected index (rr_ptr when nothing requests)
//   any_req   out 1        at least one request bit set
// -----------------------------------------------------------------------------
module rr_priority_picker
  import input_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int REQ_LOG = REQ_LOG_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_LOG-1:0] rr_ptr,
  output logic [REQ_LOG-1:0] grant_idx,
  output logic               any_req
);

  // Scan offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    uint_t idx_v;
    idx_v     = 32'd0;
    grant_idx = rr_ptr;
    any_req   = |req;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx_v     = wrap_add(uint_t'(rr_ptr), uint_t'(off), uint_t'(NUM_REQ));
      grant_idx = req[idx_v] ? REQ_LOG'(idx_v) : grant_idx;
    end
  end

endmodule

// File: rtl/input_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// input_fetch_arbiter
// Shares one input-vector SRAM read port among NUM_REQ tile controllers.
// A request is granted round-robin, one read is issued, the arbiter waits
// MEM_LATENCY cycles, captures the data and pulses input_ready to the
// granted tile. One read in flight at a time.
// Ports:
//   clock       in  1                   rising-edge clock
//   reset       in  1                   synchronous active-high reset
//   input_req   in  NUM_REQ             level request per tile
//   req_addr    in  NUM_REQ*ADDR_WIDTH  packed per-tile read address
//   mem_rd_en   out 1                   read strobe (ISSUE state)
//   mem_rd_addr out ADDR_WIDTH          latched read address
//   mem_rd_data in  DATA_WIDTH          read data, MEM_LATENCY after strobe
//   input_ready out NUM_REQ             one-hot delivery pulse (DELIVER)
//   input_data  out DATA_WIDTH          captured data, held until next capture
//   grant_id    out REQ_LOG             requester being served
//   busy        out 1                   state != IDLE
// -----------------------------------------------------------------------------
module input_fetch_arbiter
  import input_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int REQ_LOG     = REQ_LOG_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            input_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic [NUM_REQ-1:0]            input_ready,
  output logic [DATA_WIDTH-1:0]         input_data,
  output logic [REQ_LOG-1:0]            grant_id,
  output logic                          busy
);

  // Counter holds MEM_LATENCY-1 down to 0; at least one bit even for latency 1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  fetch_state_t            state_r;
  fetch_state_t            state_nxt_s;
  logic [REQ_LOG-1:0]      rr_ptr_r;
  logic [REQ_LOG-1:0]      grant_id_r;
  logic [REQ_LOG-1:0]      pick_idx_s;
  logic                    any_req_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   input_data_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    cnt_zero_s;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .REQ_LOG (REQ_LOG)
  ) u_picker (
    .req       (input_req),
    .rr_ptr    (rr_ptr_r),
    .grant_idx (pick_idx_s),
    .any_req   (any_req_s)
  );

  assign cnt_zero_s  = (cnt_r == {CNT_W{1'b0}});
  assign mem_rd_addr = addr_r;
  assign input_data  = input_data_r;
  assign grant_id    = grant_id_r;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (cnt_zero_s) begin
          state_nxt_s = DELIVER;
        end else begin
          state_nxt_s = WAIT_DATA;
        end
      end
      DELIVER: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Strobe, delivery pulse and busy flag decoded from the state register.
  always_comb begin
    mem_rd_en   = 1'b0;
    busy        = 1'b0;
    input_ready = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
      end
      WAIT_DATA: begin
        busy = 1'b1;
      end
      DELIVER: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          input_ready[i] = (grant_id_r == REQ_LOG'(i));
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Grant/address latch, latency counter, data capture and pointer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r     <= {REQ_LOG{1'b0}};
      grant_id_r   <= {REQ_LOG{1'b0}};
      addr_r       <= {ADDR_WIDTH{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      input_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // Address is captured here so later req_addr changes are ignored.
          if (any_req_s) begin
            grant_id_r <= pick_idx_s;
            addr_r     <= req_addr[int'(pick_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
        ISSUE: begin
          cnt_r <= CNT_LOAD;
        end
        WAIT_DATA: begin
          if (cnt_zero_s) begin
            input_data_r <= mem_rd_data;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DELIVER: begin
          rr_ptr_r <= REQ_LOG'(wrap_inc(uint_t'(grant_id_r), uint_t'(NUM_REQ)));
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_input_fetch_arbiter
// Directed and randomized stimulus against a transaction-level reference:
// the model tracks "cycles since grant" for the transaction in service and
// derives every expected output from that count, the round-robin rule and a
// behavioural memory array. A second instance built with MEM_LATENCY=1
// covers the shortened service period.
// -----------------------------------------------------------------------------
module tb_input_fetch_arbiter;

  localparam int N  = 4;
  localparam int RL = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int L  = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    input_req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_data;
  logic [N-1:0]    input_ready;
  logic [DW-1:0]   input_data;
  logic [RL-1:0]   grant_id;
  logic            busy;

  logic            reset1 = 1'b1;
  logic [N-1:0]    req1 = '0;
  logic [N*AW-1:0] addr1 = '0;
  logic            en1;
  logic [AW-1:0]   raddr1;
  logic [DW-1:0]   rdata1;
  logic [N-1:0]    ready1;
  logic [DW-1:0]   data1;
  logic [RL-1:0]   gid1;
  logic            busy1;

  always #5 clock = ~clock;

  input_fetch_arbiter #(.NUM_REQ(N), .REQ_LOG(RL), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .input_req(input_req), .req_addr(req_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .input_ready(input_ready), .input_data(input_data), .grant_id(grant_id),
    .busy(busy)
  );

  input_fetch_arbiter #(.NUM_REQ(N), .REQ_LOG(RL), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset1), .input_req(req1), .req_addr(addr1),
    .mem_rd_en(en1), .mem_rd_addr(raddr1), .mem_rd_data(rdata1),
    .input_ready(ready1), .input_data(data1), .grant_id(gid1),
    .busy(busy1)
  );

  // Behavioural SRAM: data appears exactly latency cycles after the strobe,
  // random junk otherwise.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [L];
  logic [DW-1:0] pipe1;

  always @(posedge clock) begin
    pipe[0] <= (mem_rd_en === 1'b1) ? mem[mem_rd_addr] : DW'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    pipe1 <= (en1 === 1'b1) ? mem[raddr1] : DW'($urandom);
  end
  assign mem_rd_data = pipe[L-1];
  assign rdata1      = pipe1;

  // Scoreboard counters and reference-model state.
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0, t1;
  bit m_active = 1'b0;
  int m_phase  = 0;   // cycles since the IDLE cycle that granted
  int m_gid    = 0;
  int m_ptr    = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]    pending = '0;
  logic [N-1:0]    keep    = '0;
  logic [N*AW-1:0] addr_nxt = '0;
  int en_cyc[$], del_cyc[$], del_id[$];
  logic [DW-1:0] del_dat[$];
  int e1[$], r1[$];
  logic [N-1:0]  r1v[$];
  logic [DW-1:0] r1d[$];
  logic [AW-1:0] e1a[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    int id;
    exp_rdy = '0;
    if (m_active && m_phase == L + 2) exp_rdy[m_gid] = 1'b1;
    chk("busy", 32'(busy), 32'(m_active));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(m_active && m_phase == 1));
    if (m_active && m_phase == 1) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(m_addr));
    chk("input_ready", 32'(input_ready), 32'(exp_rdy));
    chk("grant_id", 32'(grant_id), m_gid);
    chk("input_data", 32'(input_data), 32'(m_data));
    if (mem_rd_en === 1'b1) en_cyc.push_back(cyc);
    if (input_ready !== '0) begin
      id = -1;
      for (int i = 0; i < N; i++) if (input_ready[i] === 1'b1) id = i;
      del_cyc.push_back(cyc);
      del_id.push_back(id);
      del_dat.push_back(input_data);
    end
  endtask

  task automatic model_update();
    bit found;
    int idx;
    if (reset) begin
      m_active = 1'b0; m_phase = 0; m_ptr = 0; m_gid = 0; m_data = '0;
    end else if (!m_active) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && input_req[idx]) begin
          found = 1'b1;
          m_gid = idx;
        end
      end
      if (found) begin
        m_addr   = req_addr[m_gid*AW +: AW];
        m_active = 1'b1;
        m_phase  = 1;
      end
    end else begin
      if (m_phase == L + 1) m_data = mem[m_addr];
      if (m_phase == L + 2) begin
        m_active = 1'b0;
        m_ptr    = (m_gid + 1) % N;
        if (!keep[m_gid]) pending[m_gid] = 1'b0;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic tick(input bit rst);
    @(posedge clock);
    #1;
    reset     = rst;
    input_req = pending;
    req_addr  = addr_nxt;
    @(negedge clock);
    check_cycle();
    model_update();
    cyc++;
  endtask

  task automatic do_reset();
    pending = '0;
    keep    = '0;
    tick(1'b1);
    tick(1'b1);
    en_cyc.delete(); del_cyc.delete(); del_id.delete(); del_dat.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h12] = 8'hA5;
    @(posedge clock);

    // Single request: strobe at T+1, delivery of 0xA5 at T+4.
    do_reset();
    addr_nxt = '0;
    addr_nxt[7:0] = 8'h12;
    pending = 4'b0001;
    t0 = cyc;
    repeat (7) tick(1'b0);
    chk("t1_en_count", en_cyc.size(), 1);
    chk("t1_en_cycle", (en_cyc.size() > 0) ? en_cyc[0] : -1, t0 + 1);
    chk("t1_del_count", del_cyc.size(), 1);
    chk("t1_del_cycle", (del_cyc.size() > 0) ? del_cyc[0] : -1, t0 + 4);
    chk("t1_del_id", (del_id.size() > 0) ? del_id[0] : -1, 0);
    chk("t1_del_data", (del_dat.size() > 0) ? 32'(del_dat[0]) : 32'hFFFF_FFFF, 32'h0000_00A5);

    // All four held: served 0,1,2,3 every five cycles.
    do_reset();
    addr_nxt = {$urandom};
    pending = 4'b1111;
    t0 = cyc;
    repeat (22) tick(1'b0);
    chk("t2_del_count", del_id.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_del_id", (k < del_id.size()) ? del_id[k] : -1, k);
      chk("t2_del_cycle", (k < del_cyc.size()) ? del_cyc[k] : -1, t0 + 4 + 5 * k);
    end

    // Fairness: 0 and 2 held continuously alternate.
    do_reset();
    pending = 4'b0101;
    keep    = 4'b0101;
    repeat (27) tick(1'b0);
    chk("t3_del_count", del_id.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_del_id", (k < del_id.size()) ? del_id[k] : -1, (k % 2 == 0) ? 0 : 2);
    end
    keep = '0;

    // Reset during WAIT_DATA for requester 1: no pulse, then 1 wins again.
    do_reset();
    pending = 4'b0010;
    repeat (3) tick(1'b0);
    pending = 4'b0000;
    tick(1'b1);
    chk("t4_no_ready", del_id.size(), 0);
    pending = 4'b1010;
    t1 = cyc;
    repeat (12) tick(1'b0);
    chk("t4_first_id", (del_id.size() > 0) ? del_id[0] : -1, 1);
    chk("t4_first_cycle", (del_cyc.size() > 0) ? del_cyc[0] : -1, t1 + 4);

    // Requester 3 drops after ISSUE: still exactly one pulse, then idle.
    do_reset();
    pending = 4'b1000;
    t0 = cyc;
    repeat (2) tick(1'b0);
    pending[3] = 1'b0;
    repeat (10) tick(1'b0);
    chk("t5_del_count", del_id.size(), 1);
    chk("t5_del_id", (del_id.size() > 0) ? del_id[0] : -1, 3);
    chk("t5_del_cycle", (del_cyc.size() > 0) ? del_cyc[0] : -1, t0 + 4);
    chk("t5_idle", 32'(busy), 32'd0);

    // Randomized traffic, mid-service drops and occasional resets.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) pending[i] = 1'b1;
      end
      if (m_active && m_phase >= 2 && m_phase <= L + 1 && $urandom_range(0, 9) == 0)
        pending[m_gid] = 1'b0;
      addr_nxt = {$urandom};
      tick($urandom_range(0, 199) == 0);
    end

    // MEM_LATENCY=1 build: strobes at T+1/T+5, pulses at T+3/T+7.
    repeat (2) begin
      @(posedge clock); #1; reset1 = 1'b1;
    end
    @(posedge clock); #1;
    reset1 = 1'b0;
    req1   = 4'b0011;
    addr1  = {8'h00, 8'h00, 8'h56, 8'h34};
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (en1 === 1'b1) begin
        e1.push_back(c);
        e1a.push_back(raddr1);
      end
      if (ready1 !== '0) begin
        r1.push_back(c);
        r1v.push_back(ready1);
        r1d.push_back(data1);
      end
      @(posedge clock); #1;
    end
    chk("l1_en_cycle", (e1.size() > 0) ? e1[0] : -1, 1);
    chk("l1_en_addr", (e1a.size() > 0) ? 32'(e1a[0]) : 32'hFFFF_FFFF, 32'h0000_0034);
    chk("l1_en2_cycle", (e1.size() > 1) ? e1[1] : -1, 5);
    chk("l1_rdy_cycle", (r1.size() > 0) ? r1[0] : -1, 3);
    chk("l1_rdy_value", (r1v.size() > 0) ? 32'(r1v[0]) : 32'hFFFF_FFFF, 32'd1);
    chk("l1_rdy_data", (r1d.size() > 0) ? 32'(r1d[0]) : 32'hFFFF_FFFF, 32'(mem[8'h34]));
    chk("l1_rdy2_cycle", (r1.size() > 1) ? r1[1] : -1, 7);
    chk("l1_rdy2_value", (r1v.size() > 1) ? 32'(r1v[1]) : 32'hFFFF_FFFF, 32'd2);
    chk("l1_rdy2_data", (r1d.size() > 1) ? 32'(r1d[1]) : 32'hFFFF_FFFF, 32'(mem[8'h56]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
